mem_port_arbiter: RTL and testbench

//  Shares one single-port memory between instruction fetch (IF) and load/store (MEM) requesters.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (IF) and load/store (D) requesters.
// Build option: define ARB_FAIR_EN to alternate grants when both requesters are pending.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stallF,
  output logic              stallM
);

  localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACC = 2'd1, S_RESP = 2'd2} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              d_ready_q, d_ready_d;
  logic              grant_d_c;

`ifdef ARB_FAIR_EN
  owner_e            last_owner_q, last_owner_d;

  // Contended grants go to whoever was not served last.
  always_comb begin
    grant_d_c    = d_req & (~if_req | (last_owner_q == OWN_IF));
    last_owner_d = last_owner_q;
    if ((state_q == S_IDLE) && (if_req | d_req)) begin
      last_owner_d = grant_d_c ? OWN_D : OWN_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_owner_q <= OWN_IF;
    else     last_owner_q <= last_owner_d;
  end
`else
  always_comb begin
    grant_d_c = d_req;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ready_q  <= if_ready_d;
      d_ready_q   <= d_ready_d;
    end
  end

  // Next-state and registered-output values; the memory strobes are set one cycle ahead.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ready_d  = 1'b0;
    d_ready_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req | d_req) begin
          owner_d    = grant_d_c ? OWN_D : OWN_IF;
          mem_en_d   = 1'b1;
          mem_we_d   = grant_d_c & d_we;
          mem_addr_d = grant_d_c ? d_addr : if_addr;
          if (grant_d_c) mem_wdata_d = d_wdata;
          cnt_d      = CNT_LOAD;
          state_d    = S_ACC;
        end
      end
      S_ACC: begin
        if (cnt_q != '0) begin
          cnt_d    = cnt_q - CNT_W'(1);
          mem_en_d = 1'b1;
          mem_we_d = mem_we_q;
        end else begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!mem_we_q) d_rdata_d = mem_rdata;
            d_ready_d = 1'b1;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign if_rdata  = if_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_rdata   = d_rdata_q;
  assign d_ready   = d_ready_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stalls come from registered ready only, so no path loops back to the requests.
  assign stallF = if_req & ~if_ready_q & ~rst;
  assign stallM = d_req & ~d_ready_q & ~rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized dual-requester traffic.
module tb_mem_port_arbiter;
  parameter int unsigned MEM_LAT = 2;
  localparam logic [31:0] MASK   = 32'hFFFF_0000;
  localparam int          BUDGET = 60;

  logic        clk, rst;
  logic        if_req, if_ready, d_req, d_we, d_ready;
  logic        mem_en, mem_we, stallF, stallM;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0, failures = 0, cyc = 0;
  logic [31:0] if_q[$], d_q[$];
  logic [31:0] d_model = 32'h0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stallF(stallF), .stallM(stallM)
  );

  // Memory returns a function of the address, and garbage when not enabled.
  assign mem_rdata = mem_en ? (mem_addr ^ MASK) : 32'h0BAD_F00D;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%b expected=%b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic void push_d(input logic [31:0] a, input logic we);
    if (!we) d_model = a ^ MASK;
    d_q.push_back(d_model);
  endfunction

  // Called just after a rising edge; returns just after the edge following if_ready.
  task automatic wait_if(output int at);
    int n = 0;
    do begin @(negedge clk); n++; end while (!if_ready && n < BUDGET);
    if (!if_ready) fail_now("if_ready_timeout");
    at = cyc;
    @(posedge clk); #1;
  endtask

  task automatic wait_d(output int at);
    int n = 0;
    do begin @(negedge clk); n++; end while (!d_ready && n < BUDGET);
    if (!d_ready) fail_now("d_ready_timeout");
    at = cyc;
    @(posedge clk); #1;
  endtask

  task automatic if_access(input logic [31:0] a);
    int at;
    if_req = 1'b1; if_addr = a; if_q.push_back(a ^ MASK);
    wait_if(at);
    if_req = 1'b0;
  endtask

  task automatic d_access(input logic [31:0] a, input logic we, input logic [31:0] wd);
    int at;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; push_d(a, we);
    wait_d(at);
    d_req = 1'b0;
  endtask

  // Transaction-level monitor: derives the owner from the requests seen in the grant cycle.
  initial begin
    bit          in_acc, prev_en, own_d, last_d, p_if, p_d, p_dwe, e_we;
    int          start;
    logic [31:0] p_ifa, p_da, p_dwd, e_addr, e_wd, if_last, d_last, exp;
    in_acc = 0; prev_en = 0; last_d = 0; own_d = 0;
    if_last = 0; d_last = 0; start = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_acc = 0; prev_en = 0; last_d = 0; p_if = 0; p_d = 0;
        if_last = 0; d_last = 0;
      end else begin
        chk1("stallF_rule", stallF, if_req & ~if_ready);
        chk1("stallM_rule", stallM, d_req & ~d_ready);
        if (mem_en && !prev_en) begin
          if (in_acc) fail_now("grant_while_busy");
          if (!p_if && !p_d) fail_now("grant_without_request");
`ifdef ARB_FAIR_EN
          own_d = p_d && (!p_if || !last_d);
`else
          own_d = p_d;
`endif
          last_d = own_d;
          in_acc = 1;
          start  = cyc;
          e_addr = own_d ? p_da : p_ifa;
          e_we   = own_d && p_dwe;
          e_wd   = p_dwd;
        end
        if (mem_en) begin
          chk("mem_addr", mem_addr, e_addr);
          chk1("mem_we", mem_we, e_we);
          if (e_we) chk("mem_wdata", mem_wdata, e_wd);
        end
        if (!mem_en && prev_en) chk("burst_len", 32'(cyc - start), 32'(MEM_LAT));
        if (if_ready || d_ready) begin
          if (!in_acc) fail_now("ready_without_access");
          chk1("ready_owner_d", d_ready, own_d);
          chk1("ready_owner_if", if_ready, !own_d);
          chk("ready_latency", 32'(cyc - start), 32'(MEM_LAT));
          in_acc = 0;
        end
        if (if_ready) begin
          if (if_q.size() == 0) fail_now("if_ready_unexpected");
          else begin exp = if_q.pop_front(); chk("if_rdata", if_rdata, exp); end
          if_last = if_rdata;
        end else chk("if_rdata_hold", if_rdata, if_last);
        if (d_ready) begin
          if (d_q.size() == 0) fail_now("d_ready_unexpected");
          else begin exp = d_q.pop_front(); chk("d_rdata", d_rdata, exp); end
          d_last = d_rdata;
        end else chk("d_rdata_hold", d_rdata, d_last);
        prev_en = mem_en;
        p_if = if_req; p_d = d_req; p_dwe = d_we;
        p_ifa = if_addr; p_da = d_addr; p_dwd = d_wdata;
      end
    end
  end

  initial begin
    int t, td, ti, t1, t2;
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_en", mem_en, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_d_ready", d_ready, 1'b0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single fetch: timing of mem_en, ready and stall.
    if_req = 1'b1; if_addr = 32'h40; if_q.push_back(32'h40 ^ MASK);
    @(negedge clk);
    chk1("t1_stallF_req", stallF, 1'b1);
    chk1("t1_no_en_yet", mem_en, 1'b0);
    for (int k = 1; k <= int'(MEM_LAT); k++) begin
      @(negedge clk);
      chk1("t1_mem_en", mem_en, 1'b1);
      chk("t1_mem_addr", mem_addr, 32'h40);
      chk1("t1_stallF_acc", stallF, 1'b1);
    end
    @(negedge clk);
    chk1("t1_if_ready", if_ready, 1'b1);
    chk("t1_if_rdata", if_rdata, 32'hFFFF_0040);
    chk1("t1_stallF_done", stallF, 1'b0);
    chk1("t1_mem_en_off", mem_en, 1'b0);
    @(posedge clk); #1 if_req = 1'b0;

    // Store: write strobes, pulse, and load data untouched.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; push_d(32'h100, 1'b1);
    @(negedge clk);
    for (int k = 1; k <= int'(MEM_LAT); k++) begin
      @(negedge clk);
      chk1("t2_mem_we", mem_we, 1'b1);
      chk("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    chk1("t2_d_ready", d_ready, 1'b1);
    chk("t2_d_rdata_kept", d_rdata, 32'h0);
    @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk1("t2_d_ready_once", d_ready, 1'b0);
    @(posedge clk); #1;

    // Simultaneous requests to the same address.
    if_req = 1'b1; if_addr = 32'h8; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h8;
    if_q.push_back(32'h8 ^ MASK); push_d(32'h8, 1'b0);
    t = cyc; td = -1; ti = -1;
    for (int k = 0; k < BUDGET && (td < 0 || ti < 0); k++) begin
      @(negedge clk);
      if (d_ready) td = cyc;
      if (if_ready) ti = cyc;
      @(posedge clk); #1;
      if (td >= 0) d_req = 1'b0;
      if (ti >= 0) if_req = 1'b0;
    end
`ifdef ARB_FAIR_EN
    chk("t3_if_first", 32'(ti), 32'(t + int'(MEM_LAT) + 1));
    chk("t3_d_second", 32'(td), 32'(ti + int'(MEM_LAT) + 2));
`else
    chk("t3_d_first", 32'(td), 32'(t + int'(MEM_LAT) + 1));
    chk("t3_if_second", 32'(ti), 32'(td + int'(MEM_LAT) + 2));
`endif

    // Reset in the last access cycle aborts; the held request then completes.
    if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
    repeat (int'(MEM_LAT)) @(posedge clk);
    #1 rst = 1'b1;
    if_q.delete(); d_q.delete(); d_model = 32'h0;
    @(negedge clk);
    chk1("t4_mem_en", mem_en, 1'b0);
    chk1("t4_stallF", stallF, 1'b0);
    chk1("t4_stallM", stallM, 1'b0);
    chk1("t4_if_ready", if_ready, 1'b0);
    chk1("t4_d_ready", d_ready, 1'b0);
    chk("t4_d_rdata", d_rdata, 32'h0);
    chk("t4_if_rdata", if_rdata, 32'h0);
    d_req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    if_q.push_back(32'h200 ^ MASK);
    wait_if(t1);
    if_req = 1'b0;

    // Load withdrawn mid-access still completes; the waiting fetch follows.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; push_d(32'h300, 1'b0);
    t = cyc; td = -1; ti = -1; t2 = -1;
    for (int k = 0; k < BUDGET && ti < 0; k++) begin
      @(negedge clk);
      if (d_ready) td = cyc;
      if (if_ready) ti = cyc;
      if (mem_en && mem_addr == 32'h400 && t2 < 0) t2 = cyc;
      @(posedge clk); #1;
      if (cyc == t + 1) begin if_req = 1'b1; if_addr = 32'h400; if_q.push_back(32'h400 ^ MASK); end
      if (cyc == t + 2) d_req = 1'b0;
      if (ti >= 0) if_req = 1'b0;
    end
    chk("t5_d_ready", 32'(td), 32'(t + int'(MEM_LAT) + 1));
    chk("t5_if_grant", 32'(t2), 32'(td + 2));
    chk("t5_if_ready", 32'(ti), 32'(td + int'(MEM_LAT) + 2));

    // Back-to-back fetches: one completion per MEM_LAT+2 cycles.
    if_req = 1'b1; if_addr = 32'h0; if_q.push_back(32'h0 ^ MASK);
    wait_if(t1);
    if_addr = 32'h4; if_q.push_back(32'h4 ^ MASK);
    wait_if(t2);
    if_req = 1'b0;
    chk("t6_fetch_period", 32'(t2 - t1), 32'(MEM_LAT + 2));

    // Randomized traffic from both requesters.
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          if_access($urandom & 32'h0000_FFFC);
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          d_access($urandom & 32'h0000_FFFC, 1'($urandom_range(0, 1)), $urandom);
        end
      end
    join

    repeat (8) @(posedge clk);
    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("d_q_drained", 32'(d_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
